trivium_ctrl: RTL and testbench

TRIVIUM_CTRL -- requirements
Module: trivium_ctrl

---
 rtl/trivium_pkg.sv | 19 +
 rtl/trivium_byte_pack.sv | 53 +++++
 rtl/trivium_ctrl.sv | 140 ++++++++++++++
 tb/tb_trivium_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared types and sizing for the Trivium keystream controller.
// Holds the FSM encoding, default configuration lengths and key/IV widths.
package trivium_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam int CFG_BYTES_DEF     = 20;
    localparam int WARMUP_CYCLES_DEF = 1152;
    localparam int KEY_W             = 80;
    localparam int IV_W              = 80;
    localparam int KEY_BYTES         = KEY_W / 8;
    localparam int IV_BYTES          = IV_W / 8;

endpackage

// File: rtl/trivium_byte_pack.sv
// Serial-to-byte collector: gathers keystream bits MSB-first and presents
// each completed byte through a valid/ready output register.
module trivium_byte_pack (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_bit_en,
    input  logic       i_bit,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_data
);

    logic [6:0] r_shift;
    logic [2:0] r_cnt;
    logic       r_valid;
    logic [7:0] r_data;
    logic       w_done;

    assign w_done = i_bit_en && (r_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_done) begin
                r_data  <= {r_shift, i_bit};
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (i_bit_en) begin
                r_shift <= {r_shift[5:0], i_bit};
                r_cnt   <= r_cnt + 3'd1;
            end
            // A byte finishing on a handshake cycle replaces the old one directly.
            if (w_done) begin
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/trivium_ctrl.sv
// Trivium session controller: loads key/IV bytes, sequences core load and
// warm-up, then packs the core keystream into bytes for a valid/ready consumer.
module trivium_ctrl
    import trivium_pkg::*;
#(
    parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF,
    parameter int CFG_BYTES     = CFG_BYTES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_data,
    output logic             cfg_ready,
    input  logic             cfg_clr,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             ks_valid,
    output logic [7:0]       ks_data,
    input  logic             ks_ready,
    output logic             core_rst,
    output logic             core_enable,
    output logic [KEY_W-1:0] core_key,
    output logic [IV_W-1:0]  core_iv,
    input  logic             core_ks_bit,
    output state_t           dbg_state
);

    localparam int                WARM_W    = $clog2(WARMUP_CYCLES + 1);
    localparam logic [4:0]        CFG_FULL  = 5'(CFG_BYTES);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [4:0]          r_cfg_cnt;
    logic [WARM_W-1:0]   r_warm_cnt;
    logic [KEY_W-1:0]    r_key;
    logic [IV_W-1:0]     r_iv;
    logic                w_abort;
    logic                w_bit_en;
    logic                w_ks_valid;

    assign w_abort = stop && (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        cfg_ready   = 1'b0;
        core_rst    = 1'b0;
        core_enable = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = (r_cfg_cnt < CFG_FULL);
                if (start && !stop && (r_cfg_cnt == CFG_FULL)) begin
                    w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                busy     = 1'b1;
                core_rst = 1'b1;
                w_next   = stop ? ST_IDLE : ST_WARMUP;
            end
            ST_WARMUP: begin
                busy        = 1'b1;
                core_enable = 1'b1;
                if (stop) begin
                    w_next = ST_IDLE;
                end else if (r_warm_cnt == WARM_LAST) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy        = 1'b1;
                // Core only advances when the output register can take a new byte.
                core_enable = !w_ks_valid || ks_ready;
                if (stop) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_cnt <= '0;
            r_key     <= '0;
            r_iv      <= '0;
        end else if (r_state == ST_IDLE) begin
            if (cfg_clr) begin
                r_cfg_cnt <= '0;
            end else if (cfg_valid && cfg_ready) begin
                for (int k = 0; k < KEY_BYTES; k++) begin
                    if (r_cfg_cnt == 5'(k)) r_key[8*k +: 8] <= cfg_data;
                end
                for (int k = 0; k < IV_BYTES; k++) begin
                    if (r_cfg_cnt == 5'(k + KEY_BYTES)) r_iv[8*k +: 8] <= cfg_data;
                end
                r_cfg_cnt <= r_cfg_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm_cnt <= '0;
        end else if ((r_state == ST_WARMUP) && !stop) begin
            r_warm_cnt <= r_warm_cnt + WARM_W'(1);
        end else begin
            r_warm_cnt <= '0;
        end
    end

    assign w_bit_en = (r_state == ST_RUN) && core_enable && !stop;

    trivium_byte_pack u_pack (
        .clk      (clk),
        .i_rst    (rst),
        .i_clr    (w_abort),
        .i_bit_en (w_bit_en),
        .i_bit    (core_ks_bit),
        .i_ready  (ks_ready),
        .o_valid  (w_ks_valid),
        .o_data   (ks_data)
    );

    assign ks_valid  = w_ks_valid;
    assign core_key  = r_key;
    assign core_iv   = r_iv;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Bench for trivium_ctrl: a stand-in core emits noise during warm-up and then
// a fixed bit pattern; keystream bytes are checked against an expected queue.
module tb_trivium_ctrl;
    import trivium_pkg::*;

    localparam int WARM = 1152;
    localparam int NPAT = 6;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic        cfg_clr;
    logic        start;
    logic        stop;
    logic        busy;
    logic        ks_valid;
    logic [7:0]  ks_data;
    logic        ks_ready;
    logic        core_rst;
    logic        core_enable;
    logic [79:0] core_key;
    logic [79:0] core_iv;
    logic        core_ks_bit;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pat [NPAT] = '{8'hB2, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hA5};
    logic [79:0] exp_key;
    logic [79:0] exp_iv;
    int step_cnt = 0;

    trivium_ctrl #(.WARMUP_CYCLES(WARM), .CFG_BYTES(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .cfg_clr     (cfg_clr),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .ks_valid    (ks_valid),
        .ks_data     (ks_data),
        .ks_ready    (ks_ready),
        .core_rst    (core_rst),
        .core_enable (core_enable),
        .core_key    (core_key),
        .core_iv     (core_iv),
        .core_ks_bit (core_ks_bit),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stand-in core ----------------
    always @(posedge clk) begin
        if (core_rst) step_cnt <= 0;
        else if (core_enable) step_cnt <= step_cnt + 1;
    end

    function automatic logic core_bit(input int s);
        int idx;
        logic [7:0] b;
        if (s < WARM) return s[0] ^ s[2];
        idx = s - WARM;
        if (idx >= 8 * NPAT) return 1'b0;
        b = pat[idx / 8];
        return b[7 - (idx % 8)];
    endfunction

    assign core_ks_bit = core_bit(step_cnt);

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (ks_valid && ks_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL ks_byte: got %02h with nothing expected", ks_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (ks_data !== e) begin
                    bad++;
                    $display("FAIL ks_byte: got %02h expected %02h", ks_data, e);
                end
            end
        end
    end

    // ---------------- helpers / drivers ----------------
    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out got 0 expected 1", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'(first + i);
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic push_pattern();
        for (int i = 0; i < NPAT; i++) exp_q.push_back(pat[i]);
    endtask

    task automatic wait_ks_valid(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ks_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout(name);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        if (!done) timeout(name);
    endtask

    task automatic check_init_pulse();
        @(negedge clk);
        check("init_core_rst", 80'(core_rst), 80'd1);
        check("init_core_en", 80'(core_enable), 80'd0);
        check("init_busy", 80'(busy), 80'd1);
        tick();
        @(negedge clk);
        check("warm_core_rst", 80'(core_rst), 80'd0);
        check("warm_core_en", 80'(core_enable), 80'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [7:0] held;
        bit hit;
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_clr = 1'b0;
        start = 1'b0; stop = 1'b0; ks_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_key[8*k +: 8] = 8'(k + 1);
            exp_iv[8*k +: 8]  = 8'(k + 11);
        end

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 80'(dbg_state), 80'(ST_IDLE));
        check("rst_cfg_ready", 80'(cfg_ready), 80'd1);
        check("rst_outputs", {74'd0, busy, ks_valid, core_rst, core_enable, 2'b00}, 80'd0);
        check("rst_ks_data", 80'(ks_data), 80'd0);
        check("rst_key", core_key, 80'd0);
        check("rst_iv", core_iv, 80'd0);

        // Configuration load
        tick();
        load_bytes(1, 20);
        @(negedge clk);
        check("key_lo", 80'(core_key[7:0]), 80'h01);
        check("key_hi", 80'(core_key[79:72]), 80'h0A);
        check("iv_lo", 80'(core_iv[7:0]), 80'h0B);
        check("iv_hi", 80'(core_iv[79:72]), 80'h14);
        check("key_all", core_key, exp_key);
        check("iv_all", core_iv, exp_iv);
        tick();
        cfg_valid = 1'b1; cfg_data = 8'h15;
        @(negedge clk);
        check("cfg_full_ready", 80'(cfg_ready), 80'd0);
        tick();
        cfg_valid = 1'b0;
        check("iv_after_21st", core_iv, exp_iv);

        // Clear, start ignored while partial, then reload
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        @(negedge clk);
        check("clr_cfg_ready", 80'(cfg_ready), 80'd1);
        check("clr_key_kept", core_key, exp_key);
        tick();
        pulse_start();
        @(negedge clk);
        check("start_partial_busy", 80'(busy), 80'd0);
        tick();
        load_bytes(1, 20);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("start_stop_busy", 80'(busy), 80'd0);

        // Session 1: warm-up, first byte held under backpressure
        tick();
        push_pattern();
        ks_ready = 1'b0;
        pulse_start();
        check_init_pulse();
        wait_ks_valid("first_byte", WARM + 40);
        check("first_byte_data", 80'(ks_data), 80'hB2);
        held = ks_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_valid", 80'(ks_valid), 80'd1);
            check("hold_data", 80'(ks_data), 80'(held));
            check("hold_core_en", 80'(core_enable), 80'd0);
        end
        @(posedge clk);
        #1;
        ks_ready = 1'b1;
        n = 0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n > 0 && ks_valid) begin
                hit = 1'b1;
                break;
            end
            if (core_enable) n++;
        end
        if (!hit) timeout("next_byte");
        check("next_byte_cycles", 80'(n), 80'd8);
        wait_drain("drain1", 200);
        ks_ready = 1'b0;
        do_stop();
        @(negedge clk);
        check("stop_busy", 80'(busy), 80'd0);
        check("stop_ks_valid", 80'(ks_valid), 80'd0);

        // Session 2: abort during warm-up, then full restart
        tick();
        pulse_start();
        check_init_pulse();
        hit = 1'b0;
        for (int i = 0; i < WARM; i++) begin
            @(posedge clk);
            #1;
            if (step_cnt == 500) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) timeout("warm_500");
        do_stop();
        @(negedge clk);
        check("abort_busy", 80'(busy), 80'd0);
        check("abort_state", 80'(dbg_state), 80'(ST_IDLE));
        check("abort_key", core_key, exp_key);
        check("abort_iv", core_iv, exp_iv);
        tick();
        push_pattern();
        ks_ready = 1'b1;
        pulse_start();
        check_init_pulse();
        check("restart_key", core_key, exp_key);
        wait_drain("drain2", WARM + 120);
        ks_ready = 1'b0;
        do_stop();

        // Session 3: reset mid-session with a byte pending
        tick();
        pulse_start();
        wait_ks_valid("pending_byte", WARM + 40);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_run_ks_valid", 80'(ks_valid), 80'd0);
        check("rst_run_cfg_ready", 80'(cfg_ready), 80'd1);
        check("rst_run_busy", 80'(busy), 80'd0);
        check("rst_run_key", core_key, 80'd0);
        tick();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_run_start_ignored", 80'(busy), 80'd0);
            check("rst_run_no_valid", 80'(ks_valid), 80'd0);
        end
        tick();
        load_bytes(1, 20);
        pulse_start();
        @(negedge clk);
        check("reload_start_busy", 80'(busy), 80'd1);
        tick();
        do_stop();

        repeat (3) tick();
        check("exp_q_empty", 80'(exp_q.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
